fp_check_scoreboard: RTL and testbench
======================================

FP_CHECK_SCOREBOARD -- requirements
Module: fp_check_scoreboard

Interface
REQ-001 Parameter DEPTH, default 8, expected-entry queue depth; power of two, range 2..64.
REQ-002 Parameter CNTW, default 32, width of the pass and fail counters.
REQ-003 Port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port issue_valid  in  1  pushes an expected entry.
REQ-006 Port issue_ready  out  1  queue not full.
REQ-007 Port issue_result  in  64  expected result.
REQ-008 Port issue_flags  in  5  expected flags (NV,DZ,OF,UF,NX).
REQ-009 Port issue_fmt  in  2  format: 0 = single, otherwise double.
REQ-010 Port issue_nanchk  in  1  canonical-NaN tolerance allowed; 0 for fcmp and fcvt_f2i.
REQ-011 Port issue_last  in  1  marks the final vector.
REQ-012 Port resp_valid  in  1  DUT ready strobe.
REQ-013 Port resp_result  in  64  calculated result.
REQ-014 Port resp_flags  in  5  calculated flags.
REQ-015 Port chk_valid  out  1  comparison result valid, one-cycle pulse.
REQ-016 Port chk_fail  out  1  comparison mismatch, qualified by chk_valid.
REQ-017 Port result_diff  out  64  masked XOR of result.
REQ-018 Port flags_diff  out  5  XOR of flags.
REQ-019 Port pass_count  out  CNTW  number of passing comparisons.
REQ-020 Port fail_count  out  CNTW  number of failing comparisons.
REQ-021 Port underflow_err  out  1  sticky: resp_valid arrived while the queue was empty.
REQ-022 Port done  out  1  sticky: the entry marked last has been compared.
REQ-023 Port occupancy  out  $clog2(DEPTH)+1  current number of queued entries.

Function
REQ-024 Push SHALL occur when issue_valid and issue_ready are both high; issue_ready = (occupancy != DEPTH).
REQ-025 Pop of the head entry SHALL occur when resp_valid is high and the queue is non-empty; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-026 A push into a full queue SHALL be dropped, with no state change.
REQ-027 Pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-028 Comparison output latency SHALL be one cycle: chk_valid, chk_fail, result_diff, flags_diff and the counters are registered in the cycle after the pop.
REQ-029 Default result_diff SHALL be resp_result XOR expected result.
REQ-030 Default flags_diff SHALL be resp_flags XOR expected flags.
REQ-031 chk_fail SHALL be (result_diff != 0) or (flags_diff != 0).
REQ-032 pass_count or fail_count SHALL increment per comparison and saturate at all-ones.
REQ-033 resp_valid on an empty queue SHALL set underflow_err, increment fail_count, and assert chk_valid and chk_fail with both diffs set to all-ones.
REQ-034 done SHALL set when a popped entry has last = 1; done and underflow_err hold until reset.
REQ-035 Comparisons SHALL continue after done.

Reset
REQ-036 Reset SHALL clear the queue, pointers, occupancy, counters, chk_valid, chk_fail, the diffs, underflow_err and done; issue_ready = 1 during and after reset.
REQ-037 A reset asserted mid-operation SHALL discard pending entries immediately, and no chk_valid SHALL follow.

Configuration
REQ-038 Macro FP_CHECK_NAN_CANON_EN: when defined, entries with nanchk = 1 SHALL apply NaN masking.
REQ-039 NaN masking, fmt 0 with resp_result[31:0] = 32'h7FC00000: result_diff = {32'h0, 1'b0, resp[30:22]^exp[30:22], 22'h0}.
REQ-040 NaN masking, other fmt with resp_result = 64'h7FF8000000000000: result_diff = {1'b0, resp[62:51]^exp[62:51], 51'h0}.
REQ-041 When FP_CHECK_NAN_CANON_EN is undefined, comparison SHALL be exact XOR, and issue_nanchk is ignored.

Structure
REQ-042 The typedef of the packed queue entry (result, flags, fmt, nanchk, last) and the canonical-NaN constants SHALL reside in package fp_wire.
REQ-043 Queue storage and pointers SHALL be the sub-module fp_check_fifo, parametrised by DEPTH and the entry type width.

Verification
REQ-044 Push 3 entries, then 3 matching resp_valid -> 3 chk_valid pulses, pass_count = 3, fail_count = 0.
REQ-045 Expected 32'h7FC00001, fmt 0, nanchk 1, resp 32'h7FC00000 -> pass with macro defined, fail without.
REQ-046 Expected flags 5'h01, resp flags 5'h00 -> chk_fail = 1, flags_diff = 5'h01, fail_count = 1.
REQ-047 Push DEPTH entries, then one more push -> issue_ready = 0, the extra push is dropped; simultaneous push and pop at full -> occupancy stays DEPTH.
REQ-048 resp_valid with an empty queue -> underflow_err = 1, chk_fail = 1, result_diff = all-ones.
REQ-049 Reset asserted with 4 entries pending -> occupancy = 0, no chk_valid; last entry then compared -> done = 1.

Source files
------------

// File: rtl/fp_wire.sv
// Shared types for the FP result checker: the packed queue entry, canonical NaN
// constants and the result-difference function (masking selected by caller).
package fp_wire;

   typedef struct packed {
      logic [63:0] result;
      logic [4:0]  flags;
      logic [1:0]  fmt;
      logic        nanchk;
      logic        last;
   } fp_entry_t;

   localparam int          ENTRY_W     = $bits(fp_entry_t);
   localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
   localparam logic [63:0] CANON_NAN_D = 64'h7FF8_0000_0000_0000;

   // With masking, a canonical NaN response only has to agree on the exponent
   // and quiet bit; payload and sign differences are tolerated.
   function automatic logic [63:0] result_xor(
      input logic [63:0] exp_r,
      input logic [63:0] resp_r,
      input logic [1:0]  fmt,
      input logic        mask_en
   );
      logic [63:0] x;
      x = exp_r ^ resp_r;
      if (mask_en && (fmt == 2'd0) && (resp_r[31:0] == CANON_NAN_S))
         return {32'h0, 1'b0, x[30:22], 22'h0};
      else if (mask_en && (fmt != 2'd0) && (resp_r == CANON_NAN_D))
         return {1'b0, x[62:51], 51'h0};
      else
         return x;
   endfunction

endpackage

// File: rtl/fp_check_fifo.sv
// Expected-entry queue for fp_check_scoreboard. Push and pop arrive already
// qualified by the caller; push while full is only issued together with a pop.
module fp_check_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 73
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign rdata = mem[rd_ptr];
   assign full  = (occupancy == FULL_CNT);
   assign empty = (occupancy == '0);

   // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   occupancy <= occupancy + (AW+1)'(1);
            2'b01:   occupancy <= occupancy - (AW+1)'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: rtl/fp_check_scoreboard.sv
// In-order FP result scoreboard: queues expected results and compares them with
// DUT responses. Optional canonical-NaN tolerance: define FP_CHECK_NAN_CANON_EN.
module fp_check_scoreboard
   import fp_wire::*;
#(
   parameter int DEPTH = 8,
   parameter int CNTW  = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic [63:0]              issue_result,
   input  logic [4:0]               issue_flags,
   input  logic [1:0]               issue_fmt,
   input  logic                     issue_nanchk,
   input  logic                     issue_last,
   input  logic                     resp_valid,
   input  logic [63:0]              resp_result,
   input  logic [4:0]               resp_flags,
   output logic                     chk_valid,
   output logic                     chk_fail,
   output logic [63:0]              result_diff,
   output logic [4:0]               flags_diff,
   output logic [CNTW-1:0]          pass_count,
   output logic [CNTW-1:0]          fail_count,
   output logic                     underflow_err,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   occupancy
);

`ifdef FP_CHECK_NAN_CANON_EN
   localparam logic NAN_CANON_EN = 1'b1;
`else
   localparam logic NAN_CANON_EN = 1'b0;
`endif

   fp_entry_t   wr_entry;
   fp_entry_t   head;
   logic        full;
   logic        empty;
   logic        push_ok;
   logic        pop_ok;
   logic        under;
   logic [63:0] res_d;
   logic [4:0]  flg_d;
   logic        mis;

   assign wr_entry = '{result: issue_result, flags: issue_flags, fmt: issue_fmt,
                       nanchk: issue_nanchk, last: issue_last};

   assign issue_ready = !full;
   assign pop_ok      = resp_valid && !empty;
   assign under       = resp_valid && empty;
   // A push at full is accepted only when the head leaves in the same cycle.
   assign push_ok     = issue_valid && (!full || pop_ok);

   fp_check_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_ok),
      .pop       (pop_ok),
      .wdata     (wr_entry),
      .rdata     (head),
      .occupancy (occupancy),
      .full      (full),
      .empty     (empty)
   );

   assign res_d = result_xor(head.result, resp_result, head.fmt,
                             head.nanchk & NAN_CANON_EN);
   assign flg_d = head.flags ^ resp_flags;
   assign mis   = (res_d != '0) || (flg_d != '0);

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
      return (&c) ? c : c + CNTW'(1);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         chk_valid     <= 1'b0;
         chk_fail      <= 1'b0;
         result_diff   <= '0;
         flags_diff    <= '0;
         pass_count    <= '0;
         fail_count    <= '0;
         underflow_err <= 1'b0;
         done          <= 1'b0;
      end else begin
         chk_valid <= pop_ok || under;
         if (pop_ok) begin
            result_diff <= res_d;
            flags_diff  <= flg_d;
            chk_fail    <= mis;
            if (mis)
               fail_count <= sat_inc(fail_count);
            else
               pass_count <= sat_inc(pass_count);
            if (head.last)
               done <= 1'b1;
         end else if (under) begin
            result_diff   <= '1;
            flags_diff    <= '1;
            chk_fail      <= 1'b1;
            underflow_err <= 1'b1;
            fail_count    <= sat_inc(fail_count);
         end
      end
   end

endmodule

// File: tb/tb_fp_check_scoreboard.sv
// Scoreboard bench for fp_check_scoreboard: expected check results are queued as
// responses are driven and compared when chk_valid appears one cycle later.
module tb_fp_check_scoreboard;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        issue_valid = 1'b0;
   logic [63:0] issue_result = '0;
   logic [4:0]  issue_flags = '0;
   logic [1:0]  issue_fmt = '0;
   logic        issue_nanchk = 1'b0;
   logic        issue_last = 1'b0;
   logic        resp_valid = 1'b0;
   logic [63:0] resp_result = '0;
   logic [4:0]  resp_flags = '0;

   logic        issue_ready, chk_valid, chk_fail, underflow_err, done;
   logic [63:0] result_diff;
   logic [4:0]  flags_diff;
   logic [31:0] pass_count, fail_count;
   logic [3:0]  occupancy;

   logic        s_issue_ready, s_chk_valid, s_chk_fail, s_underflow_err, s_done;
   logic [63:0] s_result_diff;
   logic [4:0]  s_flags_diff;
   logic [1:0]  s_pass_count, s_fail_count;
   logic [3:0]  s_occupancy;

   fp_check_scoreboard #(.DEPTH(DEPTH), .CNTW(32)) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_result(issue_result), .issue_flags(issue_flags),
      .issue_fmt(issue_fmt), .issue_nanchk(issue_nanchk), .issue_last(issue_last),
      .resp_valid(resp_valid), .resp_result(resp_result), .resp_flags(resp_flags),
      .chk_valid(chk_valid), .chk_fail(chk_fail),
      .result_diff(result_diff), .flags_diff(flags_diff),
      .pass_count(pass_count), .fail_count(fail_count),
      .underflow_err(underflow_err), .done(done), .occupancy(occupancy)
   );

   // Narrow-counter copy on the same stimulus, used for saturation.
   fp_check_scoreboard #(.DEPTH(DEPTH), .CNTW(2)) dut_sat (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(s_issue_ready),
      .issue_result(issue_result), .issue_flags(issue_flags),
      .issue_fmt(issue_fmt), .issue_nanchk(issue_nanchk), .issue_last(issue_last),
      .resp_valid(resp_valid), .resp_result(resp_result), .resp_flags(resp_flags),
      .chk_valid(s_chk_valid), .chk_fail(s_chk_fail),
      .result_diff(s_result_diff), .flags_diff(s_flags_diff),
      .pass_count(s_pass_count), .fail_count(s_fail_count),
      .underflow_err(s_underflow_err), .done(s_done), .occupancy(s_occupancy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        fail;
      logic [63:0] rd;
      logic [4:0]  fd;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   passes = 0;
   int   exp_pass = 0;
   int   exp_fail = 0;
   logic nan_en;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic record(input logic fail, input logic [63:0] rd, input logic [4:0] fd);
      sb.push_back('{fail: fail, rd: rd, fd: fd});
      if (fail) exp_fail++;
      else      exp_pass++;
   endtask

   task automatic drive_push(input logic [63:0] r, input logic [4:0] f, input logic [1:0] fm,
                             input logic nc, input logic l);
      issue_valid  = 1'b1;
      issue_result = r;
      issue_flags  = f;
      issue_fmt    = fm;
      issue_nanchk = nc;
      issue_last   = l;
      tick();
      issue_valid  = 1'b0;
   endtask

   task automatic drive_resp(input logic [63:0] r, input logic [4:0] f);
      resp_valid  = 1'b1;
      resp_result = r;
      resp_flags  = f;
      tick();
      resp_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++;
      if (issue_ready !== 1'b1 || occupancy !== 4'd0 || chk_valid !== 1'b0)
         $display("FAIL reset_during: ready=%b occ=%0d valid=%b, required 1/0/0",
                  issue_ready, occupancy, chk_valid);
      else passes++;
      tick();
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (issue_ready !== 1'b1 || occupancy !== 4'd0 || chk_valid !== 1'b0 ||
          chk_fail !== 1'b0 || result_diff !== 64'd0 || flags_diff !== 5'd0 ||
          pass_count !== 32'd0 || fail_count !== 32'd0 || underflow_err !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_after: ready=%b occ=%0d valid=%b fail=%b rd=%h fd=%h pc=%0d fc=%0d uf=%b done=%b, required all idle",
                  issue_ready, occupancy, chk_valid, chk_fail, result_diff, flags_diff,
                  pass_count, fail_count, underflow_err, done);
      else passes++;
   endtask

   task automatic test_basic();
      logic [63:0] r [3];
      logic [4:0]  f [3];
      for (int i = 0; i < 3; i++) begin
         r[i] = {$urandom(), $urandom()};
         f[i] = 5'($urandom_range(0, 31));
         drive_push(r[i], f[i], 2'd1, 1'b0, 1'b0);
      end
      checks++;
      if (occupancy !== 4'd3)
         $display("FAIL basic_occ: occ=%0d, required 3", occupancy);
      else passes++;
      // Back-to-back responses, one per cycle.
      for (int i = 0; i < 3; i++) begin
         resp_valid  = 1'b1;
         resp_result = r[i];
         resp_flags  = f[i];
         record(1'b0, 64'd0, 5'd0);
         tick();
         e = sb.pop_front();
         checks++;
         if (chk_valid !== 1'b1 || chk_fail !== e.fail || result_diff !== e.rd || flags_diff !== e.fd)
            $display("FAIL basic_chk%0d: valid=%b fail=%b rd=%h fd=%h, required valid=1 fail=%b rd=%h fd=%h",
                     i, chk_valid, chk_fail, result_diff, flags_diff, e.fail, e.rd, e.fd);
         else passes++;
      end
      resp_valid = 1'b0;
      tick();
      checks++;
      if (chk_valid !== 1'b0 || pass_count !== 32'd3 || fail_count !== 32'd0 || occupancy !== 4'd0)
         $display("FAIL basic_counts: valid=%b pc=%0d fc=%0d occ=%0d, required 0/3/0/0",
                  chk_valid, pass_count, fail_count, occupancy);
      else passes++;
   endtask

   task automatic test_mismatch();
      logic [63:0] rv [2];
      logic [4:0]  ef [2];
      logic [63:0] rr [2];
      logic [4:0]  rf [2];
      rv[0] = 64'hA5A5_5A5A_0F0F_F0F0; ef[0] = 5'h01; rr[0] = rv[0];                         rf[0] = 5'h00;
      rv[1] = 64'h3FF0_0000_0000_0000; ef[1] = 5'h0C; rr[1] = rv[1] ^ 64'h8000_0000_0000_0001; rf[1] = 5'h0C;
      for (int i = 0; i < 2; i++) begin
         drive_push(rv[i], ef[i], 2'd1, 1'b0, 1'b0);
         record(1'b1, rr[i] ^ rv[i], rf[i] ^ ef[i]);
         drive_resp(rr[i], rf[i]);
         e = sb.pop_front();
         checks++;
         if (chk_valid !== 1'b1 || chk_fail !== e.fail || result_diff !== e.rd || flags_diff !== e.fd)
            $display("FAIL mismatch_chk%0d: valid=%b fail=%b rd=%h fd=%h, required valid=1 fail=%b rd=%h fd=%h",
                     i, chk_valid, chk_fail, result_diff, flags_diff, e.fail, e.rd, e.fd);
         else passes++;
         if (i == 0) begin
            checks++;
            if (fail_count !== 32'd1 || flags_diff !== 5'h01)
               $display("FAIL flags_only: fc=%0d fd=%h, required fc=1 fd=01", fail_count, flags_diff);
            else passes++;
         end
      end
      tick();
      checks++;
      if (chk_valid !== 1'b0 || pass_count !== 32'(exp_pass) || fail_count !== 32'(exp_fail))
         $display("FAIL mismatch_counts: valid=%b pc=%0d fc=%0d, required 0/%0d/%0d",
                  chk_valid, pass_count, fail_count, exp_pass, exp_fail);
      else passes++;
   endtask

   task automatic test_nan();
      logic [63:0] ev [4];
      logic [63:0] rv [4];
      logic [1:0]  fm [4];
      logic        nc [4];
      logic [63:0] masked [4];
      logic [63:0] want;
      ev[0] = 64'h0000_0000_7FC0_0001; rv[0] = 64'h0000_0000_7FC0_0000; fm[0] = 2'd0; nc[0] = 1'b1;
      masked[0] = 64'd0;
      ev[1] = 64'h7FF8_0000_0000_0123; rv[1] = 64'h7FF8_0000_0000_0000; fm[1] = 2'd1; nc[1] = 1'b1;
      masked[1] = 64'd0;
      ev[2] = 64'h0000_0000_7FC0_0001; rv[2] = 64'h0000_0000_7FC0_0000; fm[2] = 2'd0; nc[2] = 1'b0;
      masked[2] = 64'h0000_0000_0000_0001;
      ev[3] = 64'h0000_0000_7F80_0001; rv[3] = 64'h0000_0000_7FC0_0000; fm[3] = 2'd0; nc[3] = 1'b1;
      masked[3] = 64'h0000_0000_0040_0000;
      for (int i = 0; i < 4; i++) begin
         drive_push(ev[i], 5'h10, fm[i], nc[i], 1'b0);
         want = nan_en ? masked[i] : (ev[i] ^ rv[i]);
         record(want != 64'd0, want, 5'h00);
         drive_resp(rv[i], 5'h10);
         e = sb.pop_front();
         checks++;
         if (chk_valid !== 1'b1 || chk_fail !== e.fail || result_diff !== e.rd || flags_diff !== e.fd)
            $display("FAIL nan_chk%0d: valid=%b fail=%b rd=%h fd=%h, required valid=1 fail=%b rd=%h fd=%h",
                     i, chk_valid, chk_fail, result_diff, flags_diff, e.fail, e.rd, e.fd);
         else passes++;
      end
      checks++;
      if (pass_count !== 32'(exp_pass) || fail_count !== 32'(exp_fail) ||
          s_pass_count !== 2'((exp_pass > 3) ? 3 : exp_pass) ||
          s_fail_count !== 2'((exp_fail > 3) ? 3 : exp_fail))
         $display("FAIL nan_counts: pc=%0d fc=%0d spc=%0d sfc=%0d, required %0d/%0d (narrow saturating)",
                  pass_count, fail_count, s_pass_count, s_fail_count, exp_pass, exp_fail);
      else passes++;
   endtask

   task automatic test_full();
      logic [63:0] base;
      logic [63:0] newv;
      base = 64'h1234_0000_0000_0000;
      newv = 64'hCAFE_0000_0000_0077;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (issue_ready !== 1'b1)
            $display("FAIL full_ready%0d: ready=%b, required 1", i, issue_ready);
         else passes++;
         drive_push(base + 64'(i), 5'(i), 2'd1, 1'b0, 1'b0);
      end
      checks++;
      if (occupancy !== 4'(DEPTH) || issue_ready !== 1'b0)
         $display("FAIL full_state: occ=%0d ready=%b, required %0d/0", occupancy, issue_ready, DEPTH);
      else passes++;
      drive_push(64'hDEAD_DEAD_DEAD_DEAD, 5'h1F, 2'd1, 1'b0, 1'b0);
      checks++;
      if (occupancy !== 4'(DEPTH))
         $display("FAIL full_drop: occ=%0d, required %0d", occupancy, DEPTH);
      else passes++;
      // Push and pop together at full.
      issue_valid  = 1'b1;
      issue_result = newv;
      issue_flags  = 5'h02;
      resp_valid   = 1'b1;
      resp_result  = base;
      resp_flags   = 5'd0;
      record(1'b0, 64'd0, 5'd0);
      tick();
      issue_valid = 1'b0;
      resp_valid  = 1'b0;
      e = sb.pop_front();
      checks++;
      if (occupancy !== 4'(DEPTH) || chk_valid !== 1'b1 || chk_fail !== e.fail || result_diff !== e.rd)
         $display("FAIL full_pushpop: occ=%0d valid=%b fail=%b rd=%h, required occ=%0d valid=1 fail=%b rd=%h",
                  occupancy, chk_valid, chk_fail, result_diff, DEPTH, e.fail, e.rd);
      else passes++;
      for (int i = 1; i <= DEPTH; i++) begin
         resp_valid  = 1'b1;
         resp_result = (i == DEPTH) ? newv : base + 64'(i);
         resp_flags  = (i == DEPTH) ? 5'h02 : 5'(i);
         record(1'b0, 64'd0, 5'd0);
         tick();
         e = sb.pop_front();
         checks++;
         if (chk_valid !== 1'b1 || chk_fail !== e.fail || result_diff !== e.rd || flags_diff !== e.fd)
            $display("FAIL drain_chk%0d: valid=%b fail=%b rd=%h fd=%h, required valid=1 fail=%b rd=%h fd=%h",
                     i, chk_valid, chk_fail, result_diff, flags_diff, e.fail, e.rd, e.fd);
         else passes++;
      end
      resp_valid = 1'b0;
      tick();
      checks++;
      if (occupancy !== 4'd0 || done !== 1'b0 || pass_count !== 32'(exp_pass) || fail_count !== 32'(exp_fail))
         $display("FAIL drain_end: occ=%0d done=%b pc=%0d fc=%0d, required 0/0/%0d/%0d",
                  occupancy, done, pass_count, fail_count, exp_pass, exp_fail);
      else passes++;
   endtask

   task automatic test_underflow();
      checks++;
      if (underflow_err !== 1'b0)
         $display("FAIL underflow_pre: uf=%b, required 0", underflow_err);
      else passes++;
      record(1'b1, '1, '1);
      drive_resp({$urandom(), $urandom()}, 5'h00);
      e = sb.pop_front();
      checks++;
      if (chk_valid !== 1'b1 || chk_fail !== e.fail || result_diff !== e.rd || flags_diff !== e.fd ||
          underflow_err !== 1'b1 || fail_count !== 32'(exp_fail))
         $display("FAIL underflow_chk: valid=%b fail=%b rd=%h fd=%h uf=%b fc=%0d, required 1/1/%h/%h/1/%0d",
                  chk_valid, chk_fail, result_diff, flags_diff, underflow_err, fail_count, e.rd, e.fd, exp_fail);
      else passes++;
      tick();
      checks++;
      if (chk_valid !== 1'b0 || underflow_err !== 1'b1 || occupancy !== 4'd0)
         $display("FAIL underflow_sticky: valid=%b uf=%b occ=%0d, required 0/1/0",
                  chk_valid, underflow_err, occupancy);
      else passes++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++)
         drive_push(64'h5555_0000_0000_0000 + 64'(i), 5'd0, 2'd1, 1'b0, i == 3);
      checks++;
      if (occupancy !== 4'd4)
         $display("FAIL rmid_occ_pre: occ=%0d, required 4", occupancy);
      else passes++;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (occupancy !== 4'd0 || issue_ready !== 1'b1 || pass_count !== 32'd0 ||
          fail_count !== 32'd0 || underflow_err !== 1'b0 || done !== 1'b0)
         $display("FAIL rmid_async: occ=%0d ready=%b pc=%0d fc=%0d uf=%b done=%b, required 0/1/0/0/0/0",
                  occupancy, issue_ready, pass_count, fail_count, underflow_err, done);
      else passes++;
      exp_pass = 0;
      exp_fail = 0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (chk_valid !== 1'b0 || occupancy !== 4'd0)
            $display("FAIL rmid_quiet%0d: valid=%b occ=%0d, required 0/0", i, chk_valid, occupancy);
         else passes++;
      end
      drive_push(64'h4010_0000_0000_0000, 5'h01, 2'd1, 1'b0, 1'b1);
      checks++;
      if (done !== 1'b0)
         $display("FAIL done_early: done=%b, required 0", done);
      else passes++;
      record(1'b0, 64'd0, 5'd0);
      drive_resp(64'h4010_0000_0000_0000, 5'h01);
      e = sb.pop_front();
      checks++;
      if (chk_valid !== 1'b1 || chk_fail !== e.fail || done !== 1'b1 || pass_count !== 32'd1)
         $display("FAIL done_set: valid=%b fail=%b done=%b pc=%0d, required 1/%b/1/1",
                  chk_valid, chk_fail, done, pass_count, e.fail);
      else passes++;
      drive_push(64'h0000_0000_3F80_0000, 5'h00, 2'd0, 1'b0, 1'b0);
      record(1'b1, 64'h0000_0000_0000_0100, 5'h00);
      drive_resp(64'h0000_0000_3F80_0100, 5'h00);
      e = sb.pop_front();
      checks++;
      if (chk_valid !== 1'b1 || chk_fail !== e.fail || result_diff !== e.rd || done !== 1'b1 ||
          pass_count !== 32'(exp_pass) || fail_count !== 32'(exp_fail))
         $display("FAIL after_done: valid=%b fail=%b rd=%h done=%b pc=%0d fc=%0d, required 1/%b/%h/1/%0d/%0d",
                  chk_valid, chk_fail, result_diff, done, pass_count, fail_count,
                  e.fail, e.rd, exp_pass, exp_fail);
      else passes++;
   endtask

   initial begin
`ifdef FP_CHECK_NAN_CANON_EN
      nan_en = 1'b1;
`else
      nan_en = 1'b0;
`endif
      test_reset();
      test_basic();
      test_mismatch();
      test_nan();
      test_full();
      test_underflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, passed %0d of %0d", passes, checks);
      $fatal(1);
   end

endmodule
